dm_write_arbiter: RTL and testbench
===================================

Name: dm_write_arbiter

Overview:
- Sits between the four processor cores and the shared data memory.
- Collects the per-core data-memory write requests (enable, address, data) and buffers at most one pending write per core.
- Grants one write per clock to the memory's write port, round-robin, so simultaneous writes never collide.
- Back-pressures each core with a stall flag while that core's buffer is occupied.

Parameters:
- N_CORES, 4, number of requesting cores.
- ADDR_W, 12, data-memory address width.
- DATA_W, 12, data-memory word width; core bus values are truncated to the low DATA_W bits at capture.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  N_CORES  per-core write request; bit i belongs to core i+1.
- wr_addr  input  N_CORES*ADDR_W  per-core address; slice i is core i+1.
- wr_data  input  N_CORES*DATA_W  per-core write data; slice i is core i+1.
- stall  output  N_CORES  bit i high: core i+1's buffer is full and a new request would be ignored.
- mem_we  output  1  registered write strobe to data memory.
- mem_addr  output  ADDR_W  registered write address.
- mem_data  output  DATA_W  registered write data.
- busy  output  1  high while any buffer is valid or mem_we is high.

Behaviour:
- Reset, effective at the rising edge where rst=1:
  - all buffers are invalidated; pending writes are discarded, including mid-operation.
  - the round-robin pointer is set to 0.
  - mem_we=0, mem_addr=0, mem_data=0, stall=0, busy=0.
  - rst has priority over all other activity in that cycle.
- Capture: at edge E, if wr_en[i]=1 and pend_valid[i]=0, the address and data are loaded into buffer i and pend_valid[i] is set.
- stall[i] = pend_valid[i], driven from a register (no combinational path from wr_en).
- If wr_en[i]=1 while stall[i]=1, the request is ignored. The core must hold the request until stall drops.
- Arbitration is combinational over pend_valid. Starting at the pointer index, the first valid buffer in ascending order with wrap wins.
- At the next edge after a grant:
  - mem_we=1 and mem_addr/mem_data take the winning buffer's contents.
  - the winning pend_valid is cleared.
  - the pointer is set to (winner+1) mod N_CORES.
- With no valid buffer: mem_we=0, mem_addr/mem_data hold their last values, and the pointer is unchanged.
- Latency: a request present at edge E0 with an idle buffer and no competition gives mem_we=1 in the cycle after E0+1. Minimum latency is 2 cycles; throughput is 1 write per cycle.
- Simultaneous requests: all four can be captured in one edge. They drain in pointer order over 4 consecutive cycles. A core that holds its request reloads at the edge where its buffer is granted (capture uses pend_valid before that edge), so stall stays high.
- Same address from two cores: both writes are issued, in grant order. The memory ends with the later-granted value; nothing is merged or dropped.
- Fairness: a continuously requesting core waits at most N_CORES-1 grants.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- When defined, the block adds:
  - output stall_cnt, width N_CORES*16, with one 16-bit counter per core. A counter increments in each cycle where wr_en[i]=1 and stall[i]=1, saturates at 0xFFFF, and resets to 0 on rst.
  - output grant_cnt, width 16, which increments on every mem_we, wraps at 0xFFFF, and resets to 0.
- When not defined, these ports and their logic are absent and all other behaviour is identical.

Decomposition:
- Shared package dm_arb_pkg holds:
  - N_CORES_DEF=4, ADDR_W_DEF=12, DATA_W_DEF=12.
  - typedef wr_req_t {valid, addr, data}.
  - function next_rr(ptr, n).
- One sub-module, rr_arbiter. It is purely combinational: inputs are the request vector and the pointer; outputs are a one-hot grant and the winner index. It is instantiated once.
- Buffers, output register and pointer live in dm_write_arbiter.

Test Plan:
- Reset then single write: wr_en=0001, addr0=0x010, data0=0x0AB for one cycle -> stall[0] high for 1 cycle; mem_we=1, mem_addr=0x010, mem_data=0x0AB exactly 2 cycles after the request; busy then falls to 0.
- Four-way collision: all wr_en high in the same cycle, addrs 0x100..0x103, data 0x001..0x004, pointer=0 -> mem_we high 4 consecutive cycles with addresses 0x100, 0x101, 0x102, 0x103; stall bits drop in that order.
- Fairness: cores 1 and 3 request continuously with holds -> grants alternate core1/core3; no core waits more than 3 grants; no request is lost.
- Same-address race: cores 2 and 4 write 0x050 with data 0x111 and 0x222 in the same cycle, pointer=2 -> sequence 0x111 then 0x222; the memory model reads 0x222.
- Reset mid-operation: three buffers valid, rst=1 for one edge -> mem_we=0, stall=0000, busy=0, pointer=0 next cycle; no discarded write ever appears on mem_we.
- DM_ARB_STATS_EN: core 1 holds a request through 3 stalled cycles -> stall_cnt[0]=3; grant_cnt equals the mem_we count; counters read 0 after rst.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared widths, request record and round-robin helper for the data-memory write arbiter.
// Pure declarations; no clocked logic and no backpressure of its own.
package dm_arb_pkg;

  localparam int N_CORES_DEF = 4;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 12;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, ascending with wrap.
// Latency: combinational. Backpressure: none; callers hold req until granted.
module rr_arbiter
  import dm_arb_pkg::*;
#(
  parameter int N  = N_CORES_DEF,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  always_comb begin
    grant  = '0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == '0 && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        winner                     = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/dm_write_arbiter.sv
// Buffers one write per core and issues one per clock to the data memory, round-robin.
// Latency: 2 cycles request-to-mem_we. Backpressure: stall[i] = buffer i occupied.
// Optional DM_ARB_STATS_EN adds per-core stall counters and a grant counter.
module dm_write_arbiter
  import dm_arb_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CORES-1:0]        wr_en,
  input  logic [N_CORES*ADDR_W-1:0] wr_addr,
  input  logic [N_CORES*DATA_W-1:0] wr_data,
  output logic [N_CORES-1:0]        stall,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data,
`ifdef DM_ARB_STATS_EN
  output logic [N_CORES*16-1:0]     stall_cnt,
  output logic [15:0]               grant_cnt,
`endif
  output logic                      busy
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [N_CORES-1:0] pend_valid;
  logic [ADDR_W-1:0]  pend_addr [N_CORES];
  logic [DATA_W-1:0]  pend_data [N_CORES];
  logic [PW-1:0]      rr_ptr;
  logic [N_CORES-1:0] grant;
  logic [PW-1:0]      winner;
  logic               any_grant;

  rr_arbiter #(.N(N_CORES), .PW(PW)) u_rr (
    .req    (pend_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign any_grant = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= '0;
      rr_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      mem_we <= any_grant;
      if (any_grant) begin
        mem_addr <= pend_addr[winner];
        mem_data <= pend_data[winner];
        rr_ptr   <= PW'(next_rr(32'(winner), N_CORES));
      end
      // A held request refills its buffer on the very edge that drains it.
      for (int i = 0; i < N_CORES; i++) begin
        if (wr_en[i] && (!pend_valid[i] || grant[i])) begin
          pend_valid[i] <= 1'b1;
          pend_addr[i]  <= wr_addr[i*ADDR_W +: ADDR_W];
          pend_data[i]  <= wr_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign stall = pend_valid;
  assign busy  = (|pend_valid) | mem_we;

`ifdef DM_ARB_STATS_EN
  logic [15:0] stall_cnt_q [N_CORES];

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      for (int i = 0; i < N_CORES; i++) stall_cnt_q[i] <= '0;
    end else begin
      if (any_grant) grant_cnt <= grant_cnt + 16'd1;
      for (int i = 0; i < N_CORES; i++) begin
        if (wr_en[i] && pend_valid[i] && stall_cnt_q[i] != 16'hFFFF)
          stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_cnt
    assign stall_cnt[g*16 +: 16] = stall_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_dm_write_arbiter.sv
// Directed bench for dm_write_arbiter; define DM_ARB_STATS_EN to also exercise the counters.
module tb_dm_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_en;
  logic [47:0] wr_addr;
  logic [47:0] wr_data;
  logic [3:0]  stall;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_data;
  logic        busy;
`ifdef DM_ARB_STATS_EN
  logic [63:0] stall_cnt;
  logic [15:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  dm_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
`ifdef DM_ARB_STATS_EN
    .stall_cnt (stall_cnt),
    .grant_cnt (grant_cnt),
`endif
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int we_seen = 0;
  int we_base = 0;
  logic disc_seen = 1'b0;
  logic [11:0] mem_model [0:4095];

  // Memory model and write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      mem_model[mem_addr] = mem_data;
      we_seen++;
      if (mem_addr >= 12'h200 && mem_addr <= 12'h202) disc_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int core, input logic [11:0] a, input logic [11:0] d);
    wr_addr[core*12 +: 12] = a;
    wr_data[core*12 +: 12] = d;
  endtask

  initial begin
    logic [3:0] es;
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    step(); step();
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single write from core 1.
    set_req(0, 12'h010, 12'h0AB); wr_en = 4'b0001;
    step(); wr_en = '0;
    check("single_stall", stall, 4'b0001);
    check("single_we_early", mem_we, 0);
    check("single_busy", busy, 1);
    step();
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 12'h010);
    check("single_data", mem_data, 12'h0AB);
    check("single_stall_clr", stall, 0);
    step();
    check("single_we_off", mem_we, 0);
    check("single_busy_off", busy, 0);
    check("single_addr_hold", mem_addr, 12'h010);

    // Same-address race, pointer now at core 2.
    set_req(1, 12'h050, 12'h111); set_req(3, 12'h050, 12'h222); wr_en = 4'b1010;
    step(); wr_en = '0;
    check("race_stall", stall, 4'b1010);
    step();
    check("race_we1", mem_we, 1);
    check("race_addr1", mem_addr, 12'h050);
    check("race_data1", mem_data, 12'h111);
    step();
    check("race_we2", mem_we, 1);
    check("race_data2", mem_data, 12'h222);
    step();
    check("race_we_off", mem_we, 0);
    check("race_mem", mem_model[12'h050], 12'h222);

    // Four-way collision, pointer back at core 1.
    we_base = we_seen;
    for (int i = 0; i < 4; i++) set_req(i, 12'(12'h100 + i), 12'(12'h001 + i));
    wr_en = 4'b1111;
    step(); wr_en = '0;
    check("coll_stall", stall, 4'b1111);
    for (int g = 0; g < 4; g++) begin
      step();
      es = 4'b1111 << (g + 1);
      check("coll_we", mem_we, 1);
      check("coll_addr", mem_addr, 64'(12'h100 + g));
      check("coll_data", mem_data, 64'(12'h001 + g));
      check("coll_stall_drop", stall, es);
    end
    step();
    check("coll_we_off", mem_we, 0);
    check("coll_count", we_seen - we_base, 4);

    // Fairness: cores 1 and 3 hold requests continuously.
    set_req(0, 12'h0A0, 12'h00A); set_req(2, 12'h0C0, 12'h00C); wr_en = 4'b0101;
    step();
    check("fair_stall0", stall, 4'b0101);
    for (int g = 0; g < 6; g++) begin
      step();
      check("fair_we", mem_we, 1);
      check("fair_addr", mem_addr, (g % 2 == 0) ? 64'h0A0 : 64'h0C0);
      check("fair_stall", stall, 4'b0101);
    end
    wr_en = '0;
    step();
    check("fair_tail1", mem_addr, 12'h0A0);
    check("fair_tail1_stall", stall, 4'b0100);
    step();
    check("fair_tail2", mem_addr, 12'h0C0);
    check("fair_tail2_stall", stall, 0);
    step();
    check("fair_we_off", mem_we, 0);

    // Reset with three buffers pending; pointer was left at core 4.
    for (int i = 0; i < 3; i++) set_req(i, 12'(12'h200 + i), 12'(12'h0F0 + i));
    wr_en = 4'b0111;
    step(); wr_en = '0;
    check("mid_stall", stall, 4'b0111);
    rst = 1'b1;
    step();
    check("mid_we", mem_we, 0);
    check("mid_stall_clr", stall, 0);
    check("mid_busy", busy, 0);
    check("mid_addr", mem_addr, 0);
    rst = 1'b0;
    step();
    check("mid_we_after", mem_we, 0);
    check("mid_busy_after", busy, 0);
    set_req(1, 12'h301, 12'h031); set_req(3, 12'h303, 12'h033); wr_en = 4'b1010;
    step(); wr_en = '0;
    step();
    check("mid_ptr_first", mem_addr, 12'h301);
    step();
    check("mid_ptr_second", mem_addr, 12'h303);
    step();
    check("mid_we_off", mem_we, 0);
    check("mid_no_discard", disc_seen, 0);

`ifdef DM_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stat_rst_stall", stall_cnt, 0);
    check("stat_rst_grant", grant_cnt, 0);
    we_base = we_seen;
    set_req(0, 12'h3A0, 12'h055); wr_en = 4'b0001;
    repeat (4) step();
    wr_en = '0;
    check("stat_stall_cnt", stall_cnt[15:0], 3);
    check("stat_stall_others", stall_cnt[63:16], 0);
    step(); step();
    check("stat_busy", busy, 0);
    check("stat_grant_vs_we", grant_cnt, 64'(we_seen - we_base));
    check("stat_grant_cnt", grant_cnt, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stat_clr_stall", stall_cnt, 0);
    check("stat_clr_grant", grant_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
